sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in/parallel-out receiver that assembles an n-bit word from a serial bit stream, one bit per qualified strobe, and presents it in a holding register with a valid/ready handshake. It is the receive end for words shifted out serially by the universal shift register, either MSB-first or LSB-first. It sits between a serial link and a parallel consumer, and buffers one complete word while the next is being shifted in.

## Interface
- n, default 4: word width in bits, n >= 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data bit, sampled when shift_en = 1.
- shift_en  input  1  bit strobe; one bit is taken per clock with shift_en = 1.
- dir  input  1  bit order: 0 = MSB-first (shift left, enter at bit 0); 1 = LSB-first (shift right, enter at bit n-1). Sampled only on the first bit of a word.
- clear  input  1  synchronous abort of the word in progress.
- rd_ready  input  1  consumer accepts Q this cycle when valid = 1.
- Q  output  n  holding register containing the last complete word.
- valid  output  1  Q holds an unread word.
- busy  output  1  a word is partially received (bit count != 0).
- bit_cnt  output  clog2(n)  number of bits received in the current word.
- overrun  output  1  sticky: a completed word was dropped because Q was still unread.

## Operation
- Internal state:
  - shift register sr[n-1:0];
  - bit counter cnt, range 0..n-1;
  - latched direction dir_q;
  - holding register Q, with valid and overrun.
- Reset (reset_n = 0, asynchronous): sr = 0, cnt = 0, dir_q = 0, Q = 0, valid = 0, overrun = 0. Consequently busy = 0 and bit_cnt = 0.
- Priority per clock edge: reset, then clear, then shift_en.
- clear = 1:
  - sr = 0, cnt = 0, overrun = 0.
  - Q and valid are untouched; a read handshake in the same cycle still completes.
  - shift_en is ignored that cycle.
- shift_en = 1 with cnt = 0: dir_q <= dir. The bit is shifted using the new dir, not the old dir_q.
- Shift rule, using effective dir (dir when cnt = 0, otherwise dir_q):
  - 0: sr <= {sr[n-2:0], serial_in}.
  - 1: sr <= {serial_in, sr[n-1:1]}.
- shift_en = 1 with cnt < n-1: cnt <= cnt + 1.
- shift_en = 1 with cnt = n-1 (word completes): the shifted result is the word, and cnt wraps to 0.
  - If valid = 0, or valid = 1 and rd_ready = 1: Q <= word, valid <= 1.
  - Otherwise: the word is dropped, Q is unchanged, and overrun <= 1.
- Read handshake: if valid = 1 and rd_ready = 1 and no word completes that cycle, valid <= 0. rd_ready while valid = 0 has no effect.
- overrun clears only on reset or clear.
- shift_en = 0: sr, cnt and dir_q hold.

## Timing
- All state changes occur on the rising edge of clk, except reset.
- Latency: Q and valid update on the same edge that samples the nth bit, so valid is visible one clock after the final bit is presented.
- Back-to-back words need no gap. Bit n of word k and bit 1 of word k+1 arrive on consecutive strobes.
- Simultaneous completion and read in one cycle: the new word is loaded, valid stays 1, and there is no overrun.
- Reset mid-word: the partial word and any unread Q are discarded immediately, with no clock required.
- Clear mid-word: the partial bits are discarded; the next strobe is bit 1 of a new word and re-latches dir.
- A change of dir mid-word has no effect until the next word.
- Output timing: busy and bit_cnt are combinational from cnt. Q, valid and overrun are registered.

## Test plan
- Reset, then MSB-first: dir = 0, bits 1, 0, 1, 1 on four consecutive strobes.
  - Required: Q = 1011 and valid = 1 after the 4th edge.
  - Required: bit_cnt steps 1, 2, 3, 0 and busy falls with the wrap.
- LSB-first: dir = 1, bits 1, 0, 1, 1 → Q = 1101, valid = 1.
  - Toggle dir to 0 after bit 2: Q must still be 1101.
- Overrun: complete word 1011 and leave rd_ready = 0, then complete word 0110.
  - Required: Q stays 1011, overrun = 1, valid = 1.
  - Then pulse clear: overrun = 0, Q = 1011, valid = 1.
- Completion with read in the same cycle: Q = 1011 is valid, and rd_ready = 1 on the edge completing 1110.
  - Required: Q = 1110, valid = 1, overrun = 0.
  - Then rd_ready = 1 for one more cycle: valid = 0.
- Gapped strobes: shift_en deasserted for 3 cycles between bits 2 and 3 of 0101 → Q = 0101, with bit_cnt holding at 2 during the gap.
- Abort cases:
  - Assert reset_n = 0 asynchronously (off clock edge) after 2 bits: all outputs go to 0 immediately.
  - Clear after 3 bits, then send 1001: Q = 1001.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles n-bit words from a strobed bit stream
// and buffers one complete word behind a valid/ready holding register.
module sipo_deserializer #(
  parameter int n = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          serial_in,
  input  logic                          shift_en,
  input  logic                          dir,
  input  logic                          clear,
  input  logic                          rd_ready,
  output logic [n-1:0]                  Q,
  output logic                          valid,
  output logic                          busy,
  output logic [((n > 1) ? $clog2(n) : 1)-1:0] bit_cnt,
  output logic                          overrun
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  logic [n-1:0]  sr_reg, sr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          dir_q_reg, dir_q_next;
  logic [n-1:0]  q_reg, q_next;
  logic          valid_reg, valid_next;
  logic          overrun_reg, overrun_next;

  logic          eff_dir;
  logic          last_bit;
  logic [n-1:0]  shift_left;
  logic [n-1:0]  shift_right;
  logic [n-1:0]  shifted;

  // The first bit of a word uses the live dir input, later bits the latched copy.
  assign eff_dir  = (cnt_reg == '0) ? dir : dir_q_reg;
  assign last_bit = (cnt_reg == CW'(n - 1));

  genvar gi;
  generate
    for (gi = 0; gi < n; gi++) begin : g_shift
      if (gi == 0) begin : g_lo
        assign shift_left[gi]  = serial_in;
        assign shift_right[gi] = sr_reg[gi+1];
      end else if (gi == n - 1) begin : g_hi
        assign shift_left[gi]  = sr_reg[gi-1];
        assign shift_right[gi] = serial_in;
      end else begin : g_mid
        assign shift_left[gi]  = sr_reg[gi-1];
        assign shift_right[gi] = sr_reg[gi+1];
      end
    end
  endgenerate

  assign shifted = eff_dir ? shift_right : shift_left;

  always_comb begin
    sr_next      = sr_reg;
    cnt_next     = cnt_reg;
    dir_q_next   = dir_q_reg;
    q_next       = q_reg;
    overrun_next = overrun_reg;
    valid_next   = (valid_reg && rd_ready) ? 1'b0 : valid_reg;

    if (clear) begin
      sr_next      = '0;
      cnt_next     = '0;
      overrun_next = 1'b0;
    end else if (shift_en) begin
      sr_next = shifted;
      if (cnt_reg == '0) begin
        dir_q_next = dir;
      end
      if (last_bit) begin
        cnt_next = '0;
        // A read in the same cycle frees the holding register for the new word.
        if (!valid_reg || rd_ready) begin
          q_next     = shifted;
          valid_next = 1'b1;
        end else begin
          overrun_next = 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_reg      <= '0;
      cnt_reg     <= '0;
      dir_q_reg   <= 1'b0;
      q_reg       <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      sr_reg      <= sr_next;
      cnt_reg     <= cnt_next;
      dir_q_reg   <= dir_q_next;
      q_reg       <= q_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign Q       = q_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;
  assign busy    = (cnt_reg != '0);
  assign bit_cnt = cnt_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed and randomized checks of sipo_deserializer against a bit-queue reference model.
module tb_sipo_deserializer;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic         serial_in;
  logic         shift_en;
  logic         dir;
  logic         clear;
  logic         rd_ready;
  logic [N-1:0] Q;
  logic         valid;
  logic         busy;
  logic [1:0]   bit_cnt;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current word in arrival order, plus the holding register.
  int           bits_m[$];
  int           dir_m = 0;
  logic [N-1:0] q_m = '0;
  logic         valid_m = 1'b0;
  logic         overrun_m = 1'b0;
  int           word_no = 0;

  sipo_deserializer #(.n(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .shift_en  (shift_en),
    .dir       (dir),
    .clear     (clear),
    .rd_ready  (rd_ready),
    .Q         (Q),
    .valid     (valid),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"},       32'(Q),       32'(q_m));
    chk({tag, "_valid"},   32'(valid),   32'(valid_m));
    chk({tag, "_overrun"}, 32'(overrun), 32'(overrun_m));
    chk({tag, "_bitcnt"},  32'(bit_cnt), 32'(bits_m.size()));
    chk({tag, "_busy"},    32'(busy),    32'(bits_m.size() != 0));
  endtask

  function automatic logic [N-1:0] assemble(input int d);
    logic [N-1:0] w = '0;
    for (int i = 0; i < N; i++) begin
      if (d == 0) w[N-1-i] = bits_m[i][0];
      else        w[i]     = bits_m[i][0];
    end
    return w;
  endfunction

  // One clock of stimulus; the model is advanced from the same inputs, then outputs are checked.
  task automatic step(input logic se, input logic si, input logic d, input logic clr,
                      input logic rr, input string tag);
    logic [N-1:0] word;
    bit done;
    shift_en = se; serial_in = si; dir = d; clear = clr; rd_ready = rr;
    @(posedge clk);
    done = 0;
    if (clr) begin
      bits_m.delete();
      overrun_m = 1'b0;
      if (valid_m && rr) valid_m = 1'b0;
    end else begin
      if (se) begin
        if (bits_m.size() == 0) dir_m = int'(d);
        bits_m.push_back(int'(si));
        if (bits_m.size() == N) begin
          word = assemble(dir_m);
          bits_m.delete();
          done = 1;
        end
      end
      if (done) begin
        word_no++;
        if (!valid_m || rr) begin
          q_m = word; valid_m = 1'b1;
          $display("word %0d: %b dir=%0d loaded", word_no, word, dir_m);
        end else begin
          overrun_m = 1'b1;
          $display("word %0d: %b dir=%0d dropped (holding register full)", word_no, word, dir_m);
        end
      end else if (valid_m && rr) begin
        valid_m = 1'b0;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic idle(input logic rr, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, rr, tag);
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic d, input logic rr_last, input string tag);
    for (int i = 0; i < N; i++) begin
      step(1'b1, w[N-1-i], d, 1'b0, (i == N-1) ? rr_last : 1'b0, tag);
    end
  endtask

  initial begin
    reset_n = 1'b0; serial_in = 1'b0; shift_en = 1'b0; dir = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset_q_const", 32'(Q), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MSB-first 1,0,1,1 with bit_cnt stepping 1,2,3,0
    step(1, 1, 0, 0, 0, "msb1"); chk("msb_cnt1", 32'(bit_cnt), 32'd1);
    step(1, 0, 0, 0, 0, "msb2"); chk("msb_cnt2", 32'(bit_cnt), 32'd2);
    step(1, 1, 0, 0, 0, "msb3"); chk("msb_cnt3", 32'(bit_cnt), 32'd3);
    chk("msb_busy3", 32'(busy), 32'd1);
    step(1, 1, 0, 0, 0, "msb4"); chk("msb_cnt0", 32'(bit_cnt), 32'd0);
    chk("msb_busy0", 32'(busy), 32'd0);
    chk("msb_q", 32'(Q), 32'b1011);
    chk("msb_valid", 32'(valid), 32'd1);
    idle(1, "msb_read");
    chk("msb_read_valid", 32'(valid), 32'd0);

    // LSB-first 1,0,1,1 with dir toggled to 0 after bit 2
    step(1, 1, 1, 0, 0, "lsb1");
    step(1, 0, 1, 0, 0, "lsb2");
    step(1, 1, 0, 0, 0, "lsb3");
    step(1, 1, 0, 0, 0, "lsb4");
    chk("lsb_q", 32'(Q), 32'b1101);
    chk("lsb_valid", 32'(valid), 32'd1);
    idle(1, "lsb_read");

    // Overrun: second word dropped while Q unread, then clear
    send_word(4'b1011, 0, 0, "ovr_a");
    send_word(4'b0110, 0, 0, "ovr_b");
    chk("ovr_q", 32'(Q), 32'b1011);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(valid), 32'd1);
    step(0, 0, 0, 1, 0, "ovr_clear");
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_q", 32'(Q), 32'b1011);
    chk("clr_valid", 32'(valid), 32'd1);

    // Completion and read on the same edge
    send_word(4'b1110, 0, 1, "cr");
    chk("cr_q", 32'(Q), 32'b1110);
    chk("cr_valid", 32'(valid), 32'd1);
    chk("cr_overrun", 32'(overrun), 32'd0);
    idle(1, "cr_read");
    chk("cr_read_valid", 32'(valid), 32'd0);

    // Gapped strobes in 0101
    step(1, 0, 0, 0, 0, "gap1");
    step(1, 1, 0, 0, 0, "gap2");
    for (int i = 0; i < 3; i++) begin
      idle(0, "gap_idle");
      chk("gap_cnt_hold", 32'(bit_cnt), 32'd2);
    end
    step(1, 0, 0, 0, 0, "gap3");
    step(1, 1, 0, 0, 0, "gap4");
    chk("gap_q", 32'(Q), 32'b0101);

    // Asynchronous reset after two bits, off the clock edge
    step(1, 1, 0, 0, 0, "ar1");
    step(1, 1, 0, 0, 0, "ar2");
    #2;
    reset_n = 1'b0;
    #1;
    bits_m.delete(); q_m = '0; valid_m = 1'b0; overrun_m = 1'b0; dir_m = 0;
    check_model("async_reset");
    chk("ar_valid_const", 32'(valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clear after three bits, then 1001
    step(1, 1, 1, 0, 0, "cl1");
    step(1, 1, 1, 0, 0, "cl2");
    step(1, 1, 1, 0, 0, "cl3");
    step(1, 1, 1, 1, 0, "cl_clear");
    chk("cl_cnt", 32'(bit_cnt), 32'd0);
    send_word(4'b1001, 0, 0, "cl_word");
    chk("cl_q", 32'(Q), 32'b1001);
    idle(1, "cl_read");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 32) == 0,
           ($urandom % 3) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
